keypad_scanner: RTL and testbench

Upstream front end of the calculator control FSM. Drives a 4x4 matrix keypad one column at a time, synchronises and debounces the row returns, and classifies each key press. Each accepted press produces exactly one single-cycle pulse on num, OP, C or EQ, plus a 4-bit key value. These pulses feed the control FSM directly.

---
 rtl/kp_pkg.sv | 55 +++++
 rtl/keypad_scanner_if.sv | 30 +++
 rtl/kp_dwell_timer.sv | 28 ++
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kp_pkg.sv
// Shared types and the keypad map for the 4x4 matrix keypad scanner.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    typedef enum logic [1:0] {
        K_NUM,
        K_OP,
        K_CLR,
        K_EQ
    } key_class_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] val;
    } key_t;

    // Physical layout: rows 0-2 carry digits 1-9 in columns 0-2, column 3
    // holds the operators, and row 3 is C / 0 / EQ.
    function automatic key_t key_lookup(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        k.cls = K_NUM;
        k.val = 4'd0;
        if (col == 2'd3) begin
            k.cls = K_OP;
            case (row)
                2'd0:    k.val = OP_ADD;
                2'd1:    k.val = OP_SUB;
                2'd2:    k.val = OP_MUL;
                default: k.val = OP_DIV;
            endcase
        end else if (row == 2'd3) begin
            case (col)
                2'd0:    k.cls = K_CLR;
                2'd1:    k.cls = K_NUM;
                default: k.cls = K_EQ;
            endcase
        end else begin
            // digit = 3*row + col + 1
            k.val = {2'b00, row} + {1'b0, row, 1'b0} + {2'b00, col} + 4'd1;
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and control-side signals of the scanner bundled together.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       num;
    logic       OP;
    logic       C;
    logic       EQ;
    logic [3:0] key_val;

    modport master (
        input  row_n,
        output col_n,
        output num,
        output OP,
        output C,
        output EQ,
        output key_val
    );

    modport slave (
        output row_n,
        input  col_n,
        input  num,
        input  OP,
        input  C,
        input  EQ,
        input  key_val
    );
endinterface

// File: rtl/kp_dwell_timer.sv
// Free-running dwell counter; strobes on the last cycle of every column dwell.
module kp_dwell_timer #(
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic resetn,
    output logic o_sample
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..SCAN_DIV-1 and wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sample = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner, row debouncer and key classifier for a 4x4 keypad.
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_W        = 10
) (
    input  logic              clk,
    input  logic              resetn,
    keypad_scanner_if.master  bus
);

    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_rs;
    logic             w_sample;
    logic             w_hit;
    logic [1:0]       w_hitRow;
    key_t             w_key;

    state_e           r_state;
    state_e           w_stateNext;
    logic [1:0]       r_colIdx;
    logic [1:0]       w_colIdxNext;
    logic [1:0]       r_rowCap;
    logic [1:0]       w_rowCapNext;
    logic [DEB_W-1:0] r_deb;
    logic [DEB_W-1:0] w_debNext;
    logic [DEB_W-1:0] r_rel;
    logic [DEB_W-1:0] w_relNext;
    logic             w_accept;
    logic             w_advance;

    logic             r_num;
    logic             r_op;
    logic             r_clr;
    logic             r_eq;
    logic [3:0]       r_keyVal;
    logic             w_numNext;
    logic             w_opNext;
    logic             w_clrNext;
    logic             w_eqNext;
    logic [3:0]       w_keyValNext;

    kp_dwell_timer #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .resetn   (resetn),
        .o_sample (w_sample)
    );

    // Two-flop synchroniser for the asynchronous row returns (idle high).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 4'b1111;
            r_rs    <= 4'b1111;
        end else begin
            r_sync1 <= bus.row_n;
            r_rs    <= r_sync1;
        end
    end

    // A valid hit is exactly one low row; anything else reads as no key.
    always_comb begin
        w_hit    = 1'b0;
        w_hitRow = 2'd0;
        case (r_rs)
            4'b1110: begin w_hit = 1'b1; w_hitRow = 2'd0; end
            4'b1101: begin w_hit = 1'b1; w_hitRow = 2'd1; end
            4'b1011: begin w_hit = 1'b1; w_hitRow = 2'd2; end
            4'b0111: begin w_hit = 1'b1; w_hitRow = 2'd3; end
            default: begin w_hit = 1'b0; w_hitRow = 2'd0; end
        endcase
    end

    // An accepted press always lands on a hit sample of the captured row,
    // so the live hit row addresses the map.
    assign w_key = key_lookup(w_hitRow, r_colIdx);

    // Scanner state, frozen column, and debounce / release counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= SCAN;
            r_colIdx <= 2'd0;
            r_rowCap <= 2'd0;
            r_deb    <= '0;
            r_rel    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_colIdx <= w_colIdxNext;
            r_rowCap <= w_rowCapNext;
            r_deb    <= w_debNext;
            r_rel    <= w_relNext;
        end
    end

    // Decisions happen only at the dwell sample point; the column advances
    // only when the scanner gives up on or finishes with the current key.
    always_comb begin
        w_stateNext  = r_state;
        w_colIdxNext = r_colIdx;
        w_rowCapNext = r_rowCap;
        w_debNext    = r_deb;
        w_relNext    = r_rel;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_hit) begin
                        w_rowCapNext = w_hitRow;
                        w_debNext    = DEB_W'(1);
                        if (DEBOUNCE_CNT <= 1) begin
                            w_stateNext = PRESSED;
                            w_accept    = 1'b1;
                        end else begin
                            w_stateNext = DEBOUNCE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit && (w_hitRow == r_rowCap)) begin
                        w_debNext = r_deb + DEB_W'(1);
                        if (r_deb == DEB_LAST) begin
                            w_stateNext = PRESSED;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        w_stateNext = SCAN;
                        w_advance   = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_hit) begin
                        w_relNext = DEB_W'(1);
                        if (DEBOUNCE_CNT <= 1) begin
                            w_stateNext = SCAN;
                            w_advance   = 1'b1;
                        end else begin
                            w_stateNext = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!w_hit) begin
                        w_relNext = r_rel + DEB_W'(1);
                        if (r_rel == DEB_LAST) begin
                            w_stateNext = SCAN;
                            w_advance   = 1'b1;
                        end
                    end else begin
                        w_stateNext = PRESSED;
                    end
                end
                default: begin
                    w_stateNext = SCAN;
                end
            endcase
        end
        if (w_advance) begin
            w_colIdxNext = r_colIdx + 2'd1;
        end
    end

    // Turn an acceptance into exactly one class pulse and a new key value.
    always_comb begin
        w_numNext    = 1'b0;
        w_opNext     = 1'b0;
        w_clrNext    = 1'b0;
        w_eqNext     = 1'b0;
        w_keyValNext = r_keyVal;
        if (w_accept) begin
            w_keyValNext = w_key.val;
            case (w_key.cls)
                K_NUM:   w_numNext = 1'b1;
                K_OP:    w_opNext  = 1'b1;
                K_CLR:   w_clrNext = 1'b1;
                default: w_eqNext  = 1'b1;
            endcase
        end
    end

    // Registered pulses (high for the single cycle after acceptance) and held key value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_num    <= 1'b0;
            r_op     <= 1'b0;
            r_clr    <= 1'b0;
            r_eq     <= 1'b0;
            r_keyVal <= 4'd0;
        end else begin
            r_num    <= w_numNext;
            r_op     <= w_opNext;
            r_clr    <= w_clrNext;
            r_eq     <= w_eqNext;
            r_keyVal <= w_keyValNext;
        end
    end

    assign bus.col_n   = ~(4'b0001 << r_colIdx);
    assign bus.num     = r_num;
    assign bus.OP      = r_op;
    assign bus.C       = r_clr;
    assign bus.EQ      = r_eq;
    assign bus.key_val = r_keyVal;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad modelled as a resistive matrix,
// a sample-level reference model checked every cycle, a per-key vector table,
// directed corner sequences and randomized key activity.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int CNT_W    = 10;

    localparam int CL_NUM = 0;
    localparam int CL_OP  = 1;
    localparam int CL_CLR = 2;
    localparam int CL_EQ  = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_BOUNCE = 1;
    localparam int PH_HELD   = 2;
    localparam int PH_QUIET  = 3;

    typedef struct {
        logic [15:0] keys;
        int          cls;
        logic [3:0]  val;
    } vec_t;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] keys   = '0;

    vec_t        vecs[16];
    int          nChecks = 0;
    int          nFails  = 0;
    int          cyc;
    int          cnt[4];
    int          base[4];
    logic [3:0]  lastVal;

    int          mPhase;
    int          mCol;
    int          mRow;
    int          mStreak;
    int          mQuiet;
    logic [3:0]  expPulse;
    logic [3:0]  expKeyVal;
    logic [3:0]  expColN;
    logic [3:0]  pulses;

    logic [15:0] rndKeys;
    int          rndA;
    int          rndB;
    int          rndSel;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB),
        .CNT_W        (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Resistive matrix: a row reads low when a pressed key joins it to a driven (low) column.
    function automatic logic [3:0] matrixRows(input logic [15:0] k, input logic [3:0] colN);
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4+c] && !colN[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    assign bus.row_n = matrixRows(keys, bus.col_n);

    // Clock count since reset release; dwell sample cycles are those with cyc%4 == 3.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase    = PH_IDLE;
        mCol      = 0;
        mRow      = 0;
        mStreak   = 0;
        mQuiet    = 0;
        expPulse  = 4'b0000;
        expKeyVal = 4'd0;
    endtask

    task automatic modelAccept(input int row);
        expPulse  = 4'b1000 >> vecs[row*4+mCol].cls;
        expKeyVal = vecs[row*4+mCol].val;
        mPhase    = PH_HELD;
    endtask

    // One dwell sample: look at what the driven column sees and apply the press/release rules.
    task automatic modelSample();
        int hits;
        int hr;
        bit single;
        hits = 0;
        hr   = 0;
        for (int r = 0; r < 4; r++)
            if (keys[r*4+mCol]) begin
                hits++;
                hr = r;
            end
        single = (hits == 1);
        case (mPhase)
            PH_IDLE: begin
                if (single) begin
                    mRow    = hr;
                    mStreak = 1;
                    if (mStreak >= DEB) modelAccept(hr);
                    else                mPhase = PH_BOUNCE;
                end else begin
                    mCol = (mCol + 1) % 4;
                end
            end
            PH_BOUNCE: begin
                if (single && hr == mRow) begin
                    mStreak++;
                    if (mStreak >= DEB) modelAccept(hr);
                end else begin
                    mPhase = PH_IDLE;
                    mCol   = (mCol + 1) % 4;
                end
            end
            PH_HELD: begin
                if (!single) begin
                    mQuiet = 1;
                    if (mQuiet >= DEB) begin
                        mPhase = PH_IDLE;
                        mCol   = (mCol + 1) % 4;
                    end else begin
                        mPhase = PH_QUIET;
                    end
                end
            end
            default: begin
                if (!single) begin
                    mQuiet++;
                    if (mQuiet >= DEB) begin
                        mPhase = PH_IDLE;
                        mCol   = (mCol + 1) % 4;
                    end
                end else begin
                    mPhase = PH_HELD;
                end
            end
        endcase
    endtask

    // Every cycle: compare DUT against the model, tally pulses, then advance the model on sample cycles.
    always @(negedge clk) begin
        if (resetn) begin
            pulses  = {bus.num, bus.OP, bus.C, bus.EQ};
            expColN = 4'b1111;
            expColN[mCol] = 1'b0;
            checkOutput("col_n", bus.col_n, expColN);
            checkOutput("pulses", pulses, expPulse);
            checkOutput("key_val", bus.key_val, expKeyVal);
            checkOutput("onehot pulses", ($countones(pulses) <= 1), 1);
            cnt[CL_NUM] += bus.num  ? 1 : 0;
            cnt[CL_OP]  += bus.OP   ? 1 : 0;
            cnt[CL_CLR] += bus.C    ? 1 : 0;
            cnt[CL_EQ]  += bus.EQ   ? 1 : 0;
            if (pulses != 4'b0000) lastVal = bus.key_val;
            expPulse = 4'b0000;
            if (cyc % 4 == 3) modelSample();
        end
    end

    // Present a key pattern starting on a dwell boundary and hold it for n dwells.
    task automatic applyStimulus(input logic [15:0] k, input int n);
        int guard;
        guard = 0;
        while ((cyc % 4 != 0) && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        keys = k;
        repeat (4*n) @(negedge clk);
    endtask

    task automatic snap();
        #1;
        base = cnt;
    endtask

    function automatic int delta(input int cls);
        return cnt[cls] - base[cls];
    endfunction

    function automatic int totalDelta();
        return delta(CL_NUM) + delta(CL_OP) + delta(CL_CLR) + delta(CL_EQ);
    endfunction

    // Idle until the scanner is about to drive column c.
    task automatic waitForColumn(input int c);
        logic [3:0] want;
        int guard;
        guard = 0;
        while (mCol != c && guard < 8) begin
            applyStimulus(16'h0000, 1);
            guard++;
        end
        #1;
        want = 4'b1111;
        want[c] = 1'b0;
        checkOutput("align column", bus.col_n, want);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0001, CL_NUM, 4'd1};
        vecs[1]  = '{16'h0002, CL_NUM, 4'd2};
        vecs[2]  = '{16'h0004, CL_NUM, 4'd3};
        vecs[3]  = '{16'h0008, CL_OP,  4'd0};
        vecs[4]  = '{16'h0010, CL_NUM, 4'd4};
        vecs[5]  = '{16'h0020, CL_NUM, 4'd5};
        vecs[6]  = '{16'h0040, CL_NUM, 4'd6};
        vecs[7]  = '{16'h0080, CL_OP,  4'd1};
        vecs[8]  = '{16'h0100, CL_NUM, 4'd7};
        vecs[9]  = '{16'h0200, CL_NUM, 4'd8};
        vecs[10] = '{16'h0400, CL_NUM, 4'd9};
        vecs[11] = '{16'h0800, CL_OP,  4'd2};
        vecs[12] = '{16'h1000, CL_CLR, 4'd0};
        vecs[13] = '{16'h2000, CL_NUM, 4'd0};
        vecs[14] = '{16'h4000, CL_EQ,  4'd0};
        vecs[15] = '{16'h8000, CL_OP,  4'd3};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        lastVal = 4'd0;
        modelReset();

        // reset values
        resetn = 1'b0;
        keys   = '0;
        #1;
        checkOutput("reset col_n", bus.col_n, 4'b1110);
        checkOutput("reset pulses", {bus.num, bus.OP, bus.C, bus.EQ}, 4'b0000);
        checkOutput("reset key_val", bus.key_val, 4'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // every key once: exactly one pulse of the right class and value
        for (int i = 0; i < 16; i++) begin
            snap();
            applyStimulus(vecs[i].keys, 12);
            applyStimulus(16'h0000, 5);
            #1;
            checkOutput($sformatf("vec%0d class count", i), delta(vecs[i].cls), 1);
            checkOutput($sformatf("vec%0d total count", i), totalDelta(), 1);
            checkOutput($sformatf("vec%0d key_val", i), lastVal, vecs[i].val);
        end

        // '7' held 40 cycles: column frozen, one pulse, scanning resumes after release
        snap();
        applyStimulus(vecs[8].keys, 10);
        #1;
        checkOutput("held 7 col_n", bus.col_n, 4'b1110);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("7 num count", delta(CL_NUM), 1);
        checkOutput("7 total count", totalDelta(), 1);
        checkOutput("7 key_val", lastVal, 4'd7);
        checkOutput("7 scan resumed", bus.col_n, 4'b0111);

        // '5' bouncing hit/none/hit, then stable
        waitForColumn(1);
        snap();
        applyStimulus(vecs[5].keys, 1);
        applyStimulus(16'h0000, 1);
        applyStimulus(vecs[5].keys, 1);
        #1;
        checkOutput("5 bounce no pulse", totalDelta(), 0);
        applyStimulus(vecs[5].keys, 12);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("5 num count", delta(CL_NUM), 1);
        checkOutput("5 key_val", lastVal, 4'd5);

        // EQ then C
        snap();
        applyStimulus(vecs[14].keys, 12);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("EQ count", delta(CL_EQ), 1);
        checkOutput("EQ key_val", lastVal, 4'd0);
        checkOutput("EQ no C", delta(CL_CLR), 0);
        applyStimulus(vecs[12].keys, 12);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("C count", delta(CL_CLR), 1);
        checkOutput("EQ+C total", totalDelta(), 2);

        // OP- and OP* together (multi-hit), then OP- alone
        snap();
        applyStimulus(vecs[7].keys | vecs[11].keys, 12);
        #1;
        checkOutput("multi-hit no pulse", totalDelta(), 0);
        applyStimulus(vecs[7].keys, 12);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("OP- count", delta(CL_OP), 1);
        checkOutput("OP- key_val", lastVal, 4'd1);

        // '9' held 200 cycles, short release, re-press: still one pulse
        snap();
        applyStimulus(vecs[10].keys, 50);
        #1;
        checkOutput("9 no autorepeat", delta(CL_NUM), 1);
        applyStimulus(16'h0000, 2);
        applyStimulus(vecs[10].keys, 10);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("9 re-press no pulse", totalDelta(), 1);
        checkOutput("9 key_val", lastVal, 4'd9);

        // reset in the middle of debouncing '3'
        waitForColumn(2);
        snap();
        applyStimulus(vecs[2].keys, 1);
        #1;
        checkOutput("3 debounce col_n", bus.col_n, 4'b1011);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async reset col_n", bus.col_n, 4'b1110);
        checkOutput("async reset pulses", {bus.num, bus.OP, bus.C, bus.EQ}, 4'b0000);
        checkOutput("async reset key_val", bus.key_val, 4'd0);
        modelReset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        applyStimulus(vecs[2].keys, 12);
        applyStimulus(16'h0000, 5);
        #1;
        checkOutput("3 after reset count", delta(CL_NUM), 1);
        checkOutput("3 after reset total", totalDelta(), 1);
        checkOutput("3 key_val", lastVal, 4'd3);

        // randomized key activity against the reference model
        for (int w = 0; w < 120; w++) begin
            rndSel = $urandom_range(0, 99);
            if (rndSel < 40) begin
                rndKeys = keys;
            end else if (rndSel < 60) begin
                rndKeys = 16'h0000;
            end else if (rndSel < 92) begin
                rndA    = $urandom_range(0, 15);
                rndKeys = 16'h0001 << rndA;
            end else begin
                rndA    = $urandom_range(0, 15);
                rndB    = $urandom_range(0, 3) * 4 + (rndA % 4);
                rndKeys = (16'h0001 << rndA) | (16'h0001 << rndB);
            end
            applyStimulus(rndKeys, $urandom_range(1, 6));
        end
        applyStimulus(16'h0000, 6);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
